// File: rtl/proc_param_if.sv
// proc_param_if: memory/IO bus between the processor core and the system.
//   master (core side): drives ADDR, DOUT, W, Done; samples DIN, MemReady, Run.
//   slave  (memory/board side): the mirror image.
interface proc_param_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic [DW-1:0] ADDR;
  logic          MemReady;
  logic          Run;
  logic          W;
  logic          Done;

  modport master (
    input  DIN, MemReady, Run,
    output DOUT, ADDR, W, Done
  );

  modport slave (
    output DIN, MemReady, Run,
    input  DOUT, ADDR, W, Done
  );
endinterface

// File: rtl/proc_param.sv
// proc_param: parametrised multicycle processor core, 16-bit instructions,
// DW-bit datapath, variable-latency memory via MemReady.
//   Clock    : single rising-edge clock
//   Resetn   : synchronous active-low reset
//   bus      : proc_param_if.master
//              DIN (read data, instruction on DIN[15:0]), MemReady, Run in;
//              ADDR, DOUT, W (registered write strobe), Done (last cycle) out.
module proc_param #(
  parameter int unsigned DW = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  proc_param_if.master bus
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_EX1   = 3'd2;
  localparam logic [2:0] S_EX2   = 3'd3;
  localparam logic [2:0] S_EX3   = 3'd4;
  localparam logic [2:0] S_MWAIT = 3'd5;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_BR  = 3'd1;  // M=1: mvt
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;  // M=1: pop
  localparam logic [2:0] OP_ST  = 3'd5;  // M=1: push
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [2:0]    r_state;
  logic [DW-1:0] r_reg [0:7];  // r5 = sp, r7 = pc
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_g;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_dout;
  logic [15:0]   r_ir;
  logic          r_w;
  logic          r_c;
  logic          r_n;
  logic          r_z;

  logic [2:0]    w_op;
  logic [2:0]    w_x;
  logic [2:0]    w_y;
  logic          w_m;
  logic [DW-1:0] w_sext;
  logic [DW-1:0] w_mvt;
  logic [DW-1:0] w_rx;
  logic [DW-1:0] w_ry;
  logic [DW-1:0] w_opnd;
  logic [DW-1:0] w_alu_b;
  logic          w_cin;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_res;
  logic          w_cout;
  logic          w_taken;
  logic          w_done;

  assign w_op   = r_ir[15:13];
  assign w_m    = r_ir[12];
  assign w_x    = r_ir[11:9];
  assign w_y    = r_ir[2:0];
  assign w_sext = {{(DW-9){r_ir[8]}}, r_ir[8:0]};
  assign w_mvt  = {r_ir[7:0], {(DW-8){1'b0}}};
  assign w_rx   = r_reg[w_x];
  assign w_ry   = r_reg[w_y];
  assign w_opnd = w_m ? w_sext : w_ry;

  // Sub/cmp reuse the adder as A + ~B + 1, so carry out means "no borrow".
  always_comb begin
    w_alu_b = w_opnd;
    w_cin   = 1'b0;
    if (w_op == OP_SUB || w_op == OP_CMP) begin
      w_alu_b = ~w_opnd;
      w_cin   = 1'b1;
    end
    w_sum = {1'b0, r_a} + {1'b0, w_alu_b} + {{DW{1'b0}}, w_cin};
    if (w_op == OP_AND) begin
      w_res  = r_a & w_opnd;
      w_cout = 1'b0;
    end else begin
      w_res  = w_sum[DW-1:0];
      w_cout = w_sum[DW];
    end
  end

  // Branch condition selected by the X field.
  always_comb begin
    w_taken = 1'b1;
    case (w_x)
      3'd1:    w_taken = r_z;
      3'd2:    w_taken = ~r_z;
      3'd3:    w_taken = ~r_c;
      3'd4:    w_taken = r_c;
      3'd5:    w_taken = ~r_n;
      3'd6:    w_taken = r_n;
      default: w_taken = 1'b1;
    endcase
  end

  // Done marks the final cycle of each instruction; in MWAIT that is the
  // cycle in which the memory responds.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      S_EX1:   w_done = (w_op == OP_MV) || (w_op == OP_BR && (w_m || !w_taken));
      S_EX2:   w_done = (w_op == OP_CMP);
      S_EX3:   w_done = (w_op != OP_ST);
      S_MWAIT: w_done = bus.MemReady;
      default: w_done = 1'b0;
    endcase
  end

  assign bus.Done = w_done & Resetn;
  assign bus.ADDR = r_addr;
  assign bus.DOUT = r_dout;
  assign bus.W    = r_w;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= S_FETCH;
      for (int unsigned i = 0; i < 8; i++) r_reg[i] <= '0;
      r_a    <= '0;
      r_g    <= '0;
      r_addr <= '0;
      r_dout <= '0;
      r_ir   <= '0;
      r_w    <= 1'b0;
      r_c    <= 1'b0;
      r_n    <= 1'b0;
      r_z    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.Run) begin
            r_addr   <= r_reg[7];
            r_reg[7] <= r_reg[7] + ONE;
            r_state  <= S_FWAIT;
          end
        end
        S_FWAIT: begin
          if (bus.MemReady) begin
            r_ir    <= bus.DIN[15:0];
            r_state <= S_EX1;
          end
        end
        S_EX1: begin
          case (w_op)
            OP_MV: begin
              r_reg[w_x] <= w_opnd;
              r_state    <= S_FETCH;
            end
            OP_BR: begin
              if (w_m) begin
                r_reg[w_x] <= w_mvt;
                r_state    <= S_FETCH;
              end else begin
                r_a <= r_reg[7];
                if (w_x == 3'd7) r_reg[6] <= r_reg[7];
                r_state <= w_taken ? S_EX2 : S_FETCH;
              end
            end
            OP_LD: begin
              r_addr  <= w_m ? r_reg[5] : w_ry;
              r_state <= S_MWAIT;
            end
            OP_ST: begin
              if (w_m) r_reg[5] <= r_reg[5] - ONE;
              else     r_addr   <= w_ry;
              r_state <= S_EX2;
            end
            default: begin  // add, sub, and, cmp
              r_a     <= w_rx;
              r_state <= S_EX2;
            end
          endcase
        end
        S_EX2: begin
          case (w_op)
            OP_BR: begin
              r_g     <= r_a + w_sext;
              r_state <= S_EX3;
            end
            OP_ST: begin
              if (w_m) begin
                r_addr  <= r_reg[5];
                r_state <= S_EX3;
              end else begin
                r_dout  <= w_rx;
                r_w     <= 1'b1;
                r_state <= S_MWAIT;
              end
            end
            OP_ADD, OP_SUB, OP_AND, OP_CMP: begin
              r_g     <= w_res;
              r_c     <= w_cout;
              r_n     <= w_res[DW-1];
              r_z     <= (w_res == '0);
              r_state <= (w_op == OP_CMP) ? S_FETCH : S_EX3;
            end
            default: r_state <= S_FETCH;
          endcase
        end
        S_EX3: begin
          case (w_op)
            OP_BR: r_reg[7] <= r_g;
            OP_ST: begin
              r_dout <= w_rx;
              r_w    <= 1'b1;
            end
            default: r_reg[w_x] <= r_g;
          endcase
          r_state <= (w_op == OP_ST) ? S_MWAIT : S_FETCH;
        end
        S_MWAIT: begin
          if (bus.MemReady) begin
            if (w_op == OP_LD) begin
              // pop rX: the later write to rX wins when X is sp
              if (w_m) r_reg[5] <= r_reg[5] + ONE;
              r_reg[w_x] <= bus.DIN;
            end
            r_w     <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
